muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have one parameter: XLEN, default 32, operand/result width (only 32 legal).
REQ-002 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: start  input  1  request to begin an operation; sampled on clk rise while idle.
REQ-006 Port: funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 Port: rs1_val  input  32  operand A (register-file read data 1).
REQ-008 Port: rs2_val  input  32  operand B (register-file read data 2).
REQ-009 Port: rd_in  input  5  destination register index.
REQ-010 Port: flush  input  1  abort the in-flight operation.
REQ-011 Port: busy  output  1  high from accepted start until return to idle.
REQ-012 Port: done  output  1  one-cycle completion pulse.
REQ-013 Port: result  output  32  write data for the register file.
REQ-014 Port: wr  output  5  write register index for the register file.
REQ-015 Port: RegWrite  output  1  register-file write enable.

Function
REQ-016 The FSM SHALL have the states IDLE, CALC and DONE.
REQ-017 In IDLE with start=1 and flush=0, the block SHALL latch funct3, rs1_val, rs2_val and rd_in on that edge (edge N) and enter CALC.
REQ-018 CALC SHALL last exactly 32 cycles using a 6-bit iteration counter: radix-2 shift-add for multiply, restoring shift-subtract for divide.
REQ-019 Latency SHALL be fixed for every op and operand: DONE entered at edge N+33; done/result/wr valid for the cycle following edge N+33; IDLE at edge N+34.
REQ-020 busy SHALL be 1 from edge N until edge N+34; start while busy=1 SHALL be ignored.
REQ-021 Signed ops SHALL use operand magnitudes, iterate unsigned, then apply sign correction before DONE.
REQ-022 MULHSU SHALL treat rs1 as signed and rs2 as unsigned.
REQ-023 MUL SHALL return product[31:0]; MULH/MULHSU/MULHU SHALL return product[63:32].
REQ-024 Remainder sign SHALL follow the dividend, and quotient SHALL truncate toward zero.
REQ-025 Divide by zero SHALL return quotient 0xFFFFFFFF (DIV and DIVU) and remainder = dividend.
REQ-026 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL return quotient 0x80000000 and remainder 0.
REQ-027 In DONE, done SHALL be 1 and wr SHALL equal the latched rd_in.
REQ-028 In DONE, RegWrite SHALL be 1 only if the latched rd_in != 0; done SHALL pulse regardless.
REQ-029 result and wr SHALL hold their values after DONE until the next DONE.
REQ-030 flush=1 in CALC SHALL return the FSM to IDLE at the next edge, with no done and no RegWrite.
REQ-031 flush=1 in DONE SHALL NOT suppress the current done pulse.
REQ-032 If start and flush are both 1 in IDLE, flush SHALL win and no operation SHALL be accepted.
REQ-033 Operand inputs SHALL NOT affect an in-flight operation after edge N.

Reset
REQ-034 While rst_n=0, independent of clk: state SHALL be IDLE and busy, done, RegWrite SHALL be 0.
REQ-035 While rst_n=0, independent of clk: result SHALL be 0x00000000, wr SHALL be 0, and the counter and datapath registers SHALL be cleared.
REQ-036 Reset asserted mid-operation SHALL discard that operation; no done SHALL follow reset release.
REQ-037 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-038 MUL 0x00000007 * 0xFFFFFFFD -> result 0xFFFFFFEB, done exactly at cycle N+33, RegWrite=1, wr=rd_in.
REQ-039 MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF.
REQ-040 DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC.
REQ-041 DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
REQ-042 flush at cycle N+10 -> busy=0 after the next edge, no done; a start issued 2 cycles later completes normally; rd_in=0 -> done=1 with RegWrite=0.
REQ-043 rst_n=0 at cycle N+20 -> all outputs 0 immediately; no done after release; start held high during the release edge is not accepted.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between an issuing pipeline and the RV32M multiply/divide unit.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [4:0]      rd_in;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      wr;
    logic            RegWrite;

    modport master (
        output start, funct3, rs1_val, rs2_val, rd_in, flush,
        input  busy, done, result, wr, RegWrite
    );

    modport slave (
        input  start, funct3, rs1_val, rs2_val, rd_in, flush,
        output busy, done, result, wr, RegWrite
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with a fixed 33-cycle latency from accept to DONE.
//
// state | meaning
// IDLE  | waiting for start; operands latched as magnitudes on accept
// CALC  | 32 shift-add / restoring shift-subtract steps, then sign fix-up into result
// DONE  | one-cycle done pulse; register-file write when rd != 0
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_unit_if.slave bus
);
    localparam logic [5:0] ITER = 6'(XLEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [2:0]        op;
    logic [4:0]        rd_q;
    logic [5:0]        cnt;
    logic [XLEN-1:0]   acc;
    logic [XLEN-1:0]   lo;
    logic [XLEN-1:0]   b_q;
    logic              neg_q;
    logic              neg_r;
    logic              div_zero;
    logic [XLEN-1:0]   result_q;
    logic [4:0]        wr_q;

    logic              accept;
    logic              a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN-1:0]   step_acc, step_lo;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, final_val;

    assign accept = (state == IDLE) && bus.start && !bus.flush;

    // Operand signedness and magnitudes: MULHSU has a signed rs1 only, unsigned ops none.
    always_comb begin
        a_signed = bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
        b_signed = bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1];
        a_neg    = a_signed && bus.rs1_val[XLEN-1];
        b_neg    = b_signed && bus.rs2_val[XLEN-1];
        a_mag    = a_neg ? -bus.rs1_val : bus.rs1_val;
        b_mag    = b_neg ? -bus.rs2_val : bus.rs2_val;
    end

    // One unsigned iteration: divide shifts the dividend out of lo into acc, multiply shifts the product right.
    always_comb begin
        step_acc  = acc;
        step_lo   = lo;
        mul_sum   = '0;
        div_shift = '0;
        div_diff  = '0;
        if (op[2]) begin
            div_shift = {acc, lo[XLEN-1]};
            div_diff  = div_shift - {1'b0, b_q};
            if (div_diff[XLEN]) begin
                step_acc = div_shift[XLEN-1:0];
                step_lo  = {lo[XLEN-2:0], 1'b0};
            end else begin
                step_acc = div_diff[XLEN-1:0];
                step_lo  = {lo[XLEN-2:0], 1'b1};
            end
        end else begin
            mul_sum  = {1'b0, acc} + (lo[0] ? {1'b0, b_q} : '0);
            step_acc = mul_sum[XLEN:1];
            step_lo  = {mul_sum[0], lo[XLEN-1:1]};
        end
    end

    // Sign correction and result selection; divide-by-zero quotient is all ones regardless of sign.
    always_comb begin
        prod      = {acc, lo};
        prod_fix  = neg_q ? -prod : prod;
        quo_fix   = div_zero ? '1 : (neg_q ? -lo : lo);
        rem_fix   = neg_r ? -acc : acc;
        final_val = '0;
        case (op)
            3'b000:                 final_val = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_val = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_val = quo_fix;
            default:                final_val = rem_fix;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; flush aborts CALC but cannot cancel a DONE already reached.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CALC;
            CALC: begin
                if (bus.flush)         state_nxt = IDLE;
                else if (cnt == ITER)  state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from state.
    always_comb begin
        bus.busy     = (state != IDLE);
        bus.done     = (state == DONE);
        bus.RegWrite = (state == DONE) && (rd_q != 5'd0);
    end

    assign bus.result = result_q;
    assign bus.wr     = wr_q;

    // Operand latch, iteration datapath and held result/wr registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op       <= '0;
            rd_q     <= '0;
            cnt      <= '0;
            acc      <= '0;
            lo       <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            result_q <= '0;
            wr_q     <= '0;
        end else if (accept) begin
            op       <= bus.funct3;
            rd_q     <= bus.rd_in;
            cnt      <= '0;
            acc      <= '0;
            lo       <= a_mag;
            b_q      <= b_mag;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= (bus.rs2_val == '0);
        end else if (state == CALC && !bus.flush) begin
            if (cnt != ITER) begin
                cnt <= cnt + 6'd1;
                acc <= step_acc;
                lo  <= step_lo;
            end else begin
                result_q <= final_val;
                wr_q     <= rd_q;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops against an arithmetic model.
module tb_muldiv_unit;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;
    int   n_done;

    muldiv_unit_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.done) n_done++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0]        ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * $signed(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Called #1 after an edge while idle; the next edge is N. Returns #1 after edge N with junk on the inputs.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        bus.funct3  = f;
        bus.rs1_val = a;
        bus.rs2_val = b;
        bus.rd_in   = rd;
        bus.start   = 1'b1;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.funct3  = 3'($urandom);
        bus.rs1_val = $urandom;
        bus.rs2_val = $urandom;
        bus.rd_in   = 5'($urandom);
        chk("busy_at_accept", 32'(bus.busy), 32'd1);
    endtask

    // Counts edges after N until done is seen; a start pulse mid-flight must be ignored.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 5) bus.start = 1'b1;
            if (lat == 7) bus.start = 1'b0;
        end
        bus.start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp);
        int lat;
        issue(f, a, b, rd);
        wait_done(lat);
        chk({tag, "_latency"}, 32'(lat), 32'd33);
        chk({tag, "_result"}, bus.result, exp);
        chk({tag, "_wr"}, 32'(bus.wr), 32'(rd));
        chk({tag, "_regwrite"}, 32'(bus.RegWrite), 32'(rd != 5'd0));
        @(posedge clk); #1;
        chk({tag, "_idle_after"}, 32'({bus.busy, bus.done, bus.RegWrite}), 32'd0);
        chk({tag, "_hold"}, bus.result, exp);
    endtask

    initial begin
        int          lat;
        int          nd;
        logic [2:0]  f;
        logic [31:0] a, b;
        logic [4:0]  rd;

        n_chk = 0; n_pass = 0; n_done = 0;
        bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = '0;
        bus.rs1_val = '0; bus.rs2_val = '0; bus.rd_in = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_status", 32'({bus.busy, bus.done, bus.RegWrite}), 32'd0);
        chk("reset_result", bus.result, 32'd0);
        chk("reset_wr", 32'(bus.wr), 32'd0);
        rst_n = 1'b1;

        // Directed values
        run_op("mul",     3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB);
        run_op("mulh",    3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000);
        run_op("mulhu",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE);
        run_op("mulhsu",  3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd8,  32'hFFFF_FFFF);
        run_op("div",     3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd9,  32'hFFFF_FFFD);
        run_op("rem",     3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd10, 32'hFFFF_FFFF);
        run_op("divu",    3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 5'd11, 32'h7FFF_FFFC);
        run_op("div0",    3'd4, 32'h0000_0005, 32'h0000_0000, 5'd12, 32'hFFFF_FFFF);
        run_op("remu0",   3'd7, 32'h0000_0005, 32'h0000_0000, 5'd13, 32'h0000_0005);
        run_op("rem0neg", 3'd6, 32'hFFFF_FFFB, 32'h0000_0000, 5'd14, 32'hFFFF_FFFB);
        run_op("divovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000);
        run_op("removf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0000_0000);
        run_op("rd0",     3'd0, 32'h0000_0003, 32'h0000_0004, 5'd0,  32'h0000_000C);

        // start together with flush in IDLE is refused
        bus.start = 1'b1; bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        chk("start_flush_idle", 32'(bus.busy), 32'd0);

        // flush mid-CALC: no done, then a later op completes normally
        nd = n_done;
        issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3);
        repeat (10) begin @(posedge clk); #1; end
        chk("busy_before_flush", 32'(bus.busy), 32'd1);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush_calc_state", 32'({bus.busy, bus.done, bus.RegWrite}), 32'd0);
        @(posedge clk); #1;
        run_op("after_flush", 3'd5, 32'd100, 32'd7, 5'd4, 32'd14);
        chk("flush_done_count", 32'(n_done - nd), 32'd1);

        // flush during DONE leaves the pulse intact
        nd = n_done;
        issue(3'd7, 32'd100, 32'd7, 5'd21);
        wait_done(lat);
        bus.flush = 1'b1;
        #1;
        chk("flush_done_pulse", 32'({bus.done, bus.RegWrite}), 32'd3);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush_done_result", bus.result, 32'd2);
        chk("flush_done_busy", 32'(bus.busy), 32'd0);
        chk("flush_done_count2", 32'(n_done - nd), 32'd1);

        // reset mid-operation: outputs clear at once, nothing completes, start during reset ignored
        nd = n_done;
        issue(3'd0, 32'd9, 32'd9, 5'd30);
        repeat (20) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("rst_mid_status", 32'({bus.busy, bus.done, bus.RegWrite}), 32'd0);
        chk("rst_mid_result", bus.result, 32'd0);
        chk("rst_mid_wr", 32'(bus.wr), 32'd0);
        bus.start = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.start = 1'b0;
        repeat (40) begin @(posedge clk); #1; end
        chk("rst_no_done", 32'(n_done - nd), 32'd0);
        chk("rst_no_accept", 32'(bus.busy), 32'd0);

        // first edge after release accepts start
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op("first_after_rst", 3'd4, 32'hFFFF_FF00, 32'd16, 5'd1, 32'hFFFF_FFF0);

        // random ops against the arithmetic model
        for (int i = 0; i < 48; i++) begin
            f  = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            rd = 5'($urandom);
            run_op($sformatf("rnd%0d_f%0d", i, f), f, a, b, rd, ref_model(f, a, b));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
